// File: rtl/axis_out_packer_if.sv
// Stream bundle around the packer: signed result beats in (s_*), packed AXI-Stream out (m_axis_*).
interface axis_out_packer_if #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned Y_BITS  = 24,
    parameter int unsigned M_WIDTH = 64
);
    localparam int unsigned S_W = ROWS * Y_BITS;
    localparam int unsigned KW  = M_WIDTH / 8;

    logic               s_valid;
    logic               s_ready;
    logic [S_W-1:0]     s_data;
    logic               s_last;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [M_WIDTH-1:0] m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tlast;

    // Environment view: sources result beats, sinks the packed stream
    modport master (
        output s_valid, s_data, s_last, m_axis_tready,
        input  s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    // Packer view
    modport slave (
        input  s_valid, s_data, s_last, m_axis_tready,
        output s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/axis_out_packer.sv
// Converts ROWS signed results per beat to 8/16/32-bit elements and packs several beats into,
// or splits one beat across, M_WIDTH-bit AXI-Stream output beats with tkeep/tlast.
module axis_out_packer #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned Y_BITS  = 24,
    parameter int unsigned M_WIDTH = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [1:0]       cfg_mode,
    output logic             sat_flag,
    axis_out_packer_if.slave bus
);
    localparam int unsigned KW     = M_WIDTH / 8;
    localparam int unsigned IW0    = ROWS * 8;
    localparam int unsigned IW1    = ROWS * 16;
    localparam int unsigned IW2    = ROWS * 32;
    localparam int unsigned BUF_W  = (IW2 > M_WIDTH) ? IW2 : M_WIDTH;
    localparam int unsigned SLOTS0 = (IW0 < M_WIDTH) ? M_WIDTH / IW0 : 1;
    localparam int unsigned SLOTS1 = (IW1 < M_WIDTH) ? M_WIDTH / IW1 : 1;
    localparam int unsigned SLOTS2 = (IW2 < M_WIDTH) ? M_WIDTH / IW2 : 1;
    localparam int unsigned PCS0   = (IW0 > M_WIDTH) ? IW0 / M_WIDTH : 1;
    localparam int unsigned PCS1   = (IW1 > M_WIDTH) ? IW1 / M_WIDTH : 1;
    localparam int unsigned PCS2   = (IW2 > M_WIDTH) ? IW2 / M_WIDTH : 1;
    localparam int unsigned CNT_W  = $clog2(KW) + 1;
    localparam int unsigned REM_W  = $clog2(PCS2) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic               pkt_open;
    logic [CNT_W-1:0]   cnt;
    logic [M_WIDTH-1:0] acc;
    logic [BUF_W-1:0]   sbuf;
    logic [REM_W-1:0]   rem;
    logic               split_last;
    logic               tvalid;
    logic [M_WIDTH-1:0] tdata;
    logic [KW-1:0]      tkeep;
    logic               tlast;

    int                 yv;
    logic [ROWS*8-1:0]  c8;
    logic [ROWS*16-1:0] c16;
    logic [ROWS*32-1:0] c32;
    logic               sat8;
    logic               sat16;
    logic [1:0]         cfg_n;
    logic [1:0]         mode_eff;
    logic [BUF_W-1:0]   chunk;
    logic               sat_hit;
    int unsigned        iw_sel;
    int unsigned        slots_sel;
    int unsigned        pcs_sel;
    int unsigned        kb;
    logic               slot_last;
    logic [M_WIDTH-1:0] acc_next;
    logic [KW-1:0]      keep_next;
    logic               hs;
    logic               ready;
    logic               accept;

    // Per-row conversion into all three element widths in parallel
    always_comb begin
        c8    = '0;
        c16   = '0;
        c32   = '0;
        sat8  = 1'b0;
        sat16 = 1'b0;
        yv    = 0;
        for (int r = 0; r < int'(ROWS); r++) begin
            yv = int'($signed(bus.s_data[r*Y_BITS +: Y_BITS]));
            if (yv > 127) begin
                c8[r*8 +: 8] = 8'h7F;
                sat8         = 1'b1;
            end else if (yv < -128) begin
                c8[r*8 +: 8] = 8'h80;
                sat8         = 1'b1;
            end else begin
                c8[r*8 +: 8] = yv[7:0];
            end
            if (yv > 32767) begin
                c16[r*16 +: 16] = 16'h7FFF;
                sat16           = 1'b1;
            end else if (yv < -32768) begin
                c16[r*16 +: 16] = 16'h8000;
                sat16           = 1'b1;
            end else begin
                c16[r*16 +: 16] = yv[15:0];
            end
            c32[r*32 +: 32] = yv;
        end
    end

    // Mode is frozen while an input packet is open; PASS and SPLIT behave as one-slot packing
    always_comb begin
        cfg_n     = (cfg_mode == 2'd3) ? 2'd2 : cfg_mode;
        mode_eff  = pkt_open ? mode_q : cfg_n;
        chunk     = '0;
        sat_hit   = 1'b0;
        iw_sel    = IW2;
        slots_sel = SLOTS2;
        pcs_sel   = PCS2;
        case (mode_eff)
            2'd0: begin
                chunk = BUF_W'(c8);  sat_hit = sat8;  iw_sel = IW0; slots_sel = SLOTS0; pcs_sel = PCS0;
            end
            2'd1: begin
                chunk = BUF_W'(c16); sat_hit = sat16; iw_sel = IW1; slots_sel = SLOTS1; pcs_sel = PCS1;
            end
            default: begin
                chunk = BUF_W'(c32); sat_hit = 1'b0;  iw_sel = IW2; slots_sel = SLOTS2; pcs_sel = PCS2;
            end
        endcase
        slot_last = (cnt == CNT_W'(slots_sel - 1));
        acc_next  = acc | (M_WIDTH'(chunk) << (32'(cnt) * iw_sel));
        kb        = (32'(cnt) + 1) * (iw_sel / 8);
        keep_next = '0;
        for (int unsigned b = 0; b < KW; b++) begin
            keep_next[b] = (b < kb);
        end
    end

    always_comb begin
        hs     = tvalid && bus.m_axis_tready;
        ready  = aresetn && (!tvalid || bus.m_axis_tready) && (rem == '0);
        accept = bus.s_valid && ready;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            pkt_open   <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            sbuf       <= '0;
            rem        <= '0;
            split_last <= 1'b0;
            tvalid     <= 1'b0;
            tdata      <= '0;
            tkeep      <= '0;
            tlast      <= 1'b0;
            sat_flag   <= 1'b0;
        end else if (accept) begin
            mode_q   <= mode_eff;
            pkt_open <= !bus.s_last;
            if (sat_hit) sat_flag <= 1'b1;
            if (slot_last || bus.s_last) begin
                tvalid     <= 1'b1;
                tdata      <= acc_next;
                tkeep      <= keep_next;
                tlast      <= bus.s_last && (pcs_sel == 1);
                acc        <= '0;
                cnt        <= '0;
                sbuf       <= chunk >> M_WIDTH;
                rem        <= REM_W'(pcs_sel - 1);
                split_last <= bus.s_last;
                state      <= (bus.s_last || pcs_sel > 1) ? FLUSH : ACTIVE;
            end else begin
                acc   <= acc_next;
                cnt   <= cnt + CNT_W'(1);
                state <= ACTIVE;
                if (hs) tvalid <= 1'b0;
            end
        end else if (hs) begin
            // Next split piece, or the output stage drains
            if (rem != '0) begin
                tdata <= M_WIDTH'(sbuf);
                sbuf  <= sbuf >> M_WIDTH;
                rem   <= rem - REM_W'(1);
                tlast <= split_last && (rem == REM_W'(1));
            end else begin
                tvalid <= 1'b0;
                if (state == FLUSH) state <= tlast ? IDLE : ACTIVE;
            end
        end
    end

    assign bus.s_ready       = ready;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tkeep  = tkeep;
    assign bus.m_axis_tlast  = tlast;
endmodule
